// File: rtl/qam_upsamp_pkg.sv
// qam_upsamp_pkg
// Shared types and helpers for the QAM I/Q interpolating FIR.
//   state_t    : interpolator sequencing states (S_WAIT, S_STUFF)
//   acc_width  : width of the signed MAC accumulator for a given geometry
//   sat_round  : round-half-up arithmetic right shift followed by saturation
package qam_upsamp_pkg;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_STUFF = 1'b1
    } state_t;

    function automatic int acc_width(input int sym_w, input int coef_w, input int ntaps);
        return sym_w + coef_w + $clog2(ntaps);
    endfunction

    // Operates on a 64-bit signed container so it serves any accumulator width;
    // the caller truncates the result to out_w bits, which is lossless after
    // saturation.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        r = acc;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (out_w - 1));
        if (r > maxv) begin
            r = maxv;
        end else if (r < minv) begin
            r = minv;
        end
        return r;
    endfunction

endpackage

// File: rtl/upsamp_capture_buf.sv
// upsamp_capture_buf
// Snapshot RAM for the interpolator output stream.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_cap_arm     : clears write pointer and done flag, restarting capture
//   i_wr_en       : one output sample handed to the sink this cycle
//   i_wr_data     : {I,Q} sample to store
//   o_cap_done    : DEPTH entries stored; writes stop until re-armed
//   i_rd_addr     : read address
//   o_rd_data     : registered read data, one cycle latency
module upsamp_capture_buf #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cap_arm,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_cap_done,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_ptr;
    logic              r_done;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_wr;

    // Arm has priority so a sample coinciding with the arm is not kept.
    assign w_wr = i_wr_en && !r_done && !i_cap_arm;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr     <= '0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
            if (i_cap_arm) begin
                r_ptr  <= '0;
                r_done <= 1'b0;
            end else if (w_wr) begin
                r_ptr <= r_ptr + AW'(1);
                if (r_ptr == AW'(DEPTH - 1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_cap_done = r_done;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/qam_iq_interp_fir.sv
// qam_iq_interp_fir
// I/Q zero-stuffing interpolator with a shared runtime-loadable FIR, rounding,
// saturation and a valid/ready output stream.
// Optional capture buffer enabled by defining macro UPSAMP_CAPTURE_EN.
//   clk, rst               : clock, synchronous active-high reset
//   sym_i, sym_q           : signed input symbols
//   sym_valid / sym_ready  : input handshake
//   up_rate                : interpolation factor, latched per accepted symbol
//   coef_we/addr/data      : coefficient bank write port
//   out_i, out_q           : filtered signed samples
//   out_valid / out_ready  : output handshake
//   cap_arm, cap_done      : capture control/status
//   cap_rd_addr/rd_data    : capture read port ({I,Q}, one cycle latency)
module qam_iq_interp_fir
    import qam_upsamp_pkg::*;
#(
    parameter int SYM_W     = 3,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 16,
    parameter int MAX_L     = 16,
    parameter int OUT_W     = 10,
    parameter int SHIFT     = 7,
    parameter int CAP_DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [SYM_W-1:0]      sym_i,
    input  logic signed [SYM_W-1:0]      sym_q,
    input  logic                         sym_valid,
    output logic                         sym_ready,
    input  logic [$clog2(MAX_L+1)-1:0]   up_rate,
    input  logic                         coef_we,
    input  logic [$clog2(NTAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]     coef_data,
    output logic signed [OUT_W-1:0]      out_i,
    output logic signed [OUT_W-1:0]      out_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         cap_arm,
    output logic                         cap_done,
    input  logic [$clog2(CAP_DEPTH)-1:0] cap_rd_addr,
    output logic [2*OUT_W-1:0]           cap_rd_data
);
    localparam int LW    = $clog2(MAX_L + 1);
    localparam int ACC_W = acc_width(SYM_W, COEF_W, NTAPS);

    state_t                    r_state;
    logic [LW-1:0]             r_len;
    logic [LW-1:0]             r_phase;
    logic signed [SYM_W-1:0]   r_line_i [NTAPS];
    logic signed [SYM_W-1:0]   r_line_q [NTAPS];
    logic signed [COEF_W-1:0]  r_coef   [NTAPS];
    logic signed [OUT_W-1:0]   r_out_i_p1;
    logic signed [OUT_W-1:0]   r_out_q_p1;
    logic                      r_vld_p1;

    logic                      w_adv;
    logic                      w_accept;
    logic                      w_push;
    logic [LW-1:0]             w_len_new;
    logic signed [SYM_W-1:0]   w_push_i;
    logic signed [SYM_W-1:0]   w_push_q;
    logic signed [SYM_W-1:0]   w_nl_i [NTAPS];
    logic signed [SYM_W-1:0]   w_nl_q [NTAPS];
    logic signed [ACC_W-1:0]   w_acc_i;
    logic signed [ACC_W-1:0]   w_acc_q;

    assign w_adv     = !r_vld_p1 || out_ready;
    assign sym_ready = (r_state == S_WAIT) && w_adv;
    assign w_accept  = sym_valid && sym_ready;
    assign w_push    = w_accept || ((r_state == S_STUFF) && w_adv);
    // Outside S_WAIT the only thing ever pushed is a stuffed zero.
    assign w_push_i  = (r_state == S_WAIT) ? sym_i : '0;
    assign w_push_q  = (r_state == S_WAIT) ? sym_q : '0;

    always_comb begin
        w_len_new = up_rate;
        if (up_rate == '0) begin
            w_len_new = LW'(1);
        end else if (int'(up_rate) > MAX_L) begin
            w_len_new = LW'(MAX_L);
        end
    end

    // Filter runs on the line contents as they will be after this push, using
    // the coefficients currently in the bank.
    always_comb begin
        w_nl_i[0] = w_push_i;
        w_nl_q[0] = w_push_q;
        for (int k = 1; k < NTAPS; k++) begin
            w_nl_i[k] = r_line_i[k-1];
            w_nl_q[k] = r_line_q[k-1];
        end
        w_acc_i = '0;
        w_acc_q = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_acc_i = w_acc_i + ACC_W'(w_nl_i[k]) * ACC_W'(r_coef[k]);
            w_acc_q = w_acc_q + ACC_W'(w_nl_q[k]) * ACC_W'(r_coef[k]);
        end
    end

    // ---- output register stage (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_WAIT;
            r_len      <= LW'(1);
            r_phase    <= '0;
            r_out_i_p1 <= '0;
            r_out_q_p1 <= '0;
            r_vld_p1   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                r_line_i[k] <= '0;
                r_line_q[k] <= '0;
                r_coef[k]   <= '0;
            end
        end else begin
            if (coef_we && (int'(coef_addr) < NTAPS)) begin
                r_coef[coef_addr] <= coef_data;
            end
            if (w_push) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_line_i[k] <= w_nl_i[k];
                    r_line_q[k] <= w_nl_q[k];
                end
                r_out_i_p1 <= OUT_W'(sat_round(64'(w_acc_i), SHIFT, OUT_W));
                r_out_q_p1 <= OUT_W'(sat_round(64'(w_acc_q), SHIFT, OUT_W));
                r_vld_p1   <= 1'b1;
            end else if (w_adv) begin
                // Idle in S_WAIT: the stream simply pauses.
                r_vld_p1 <= 1'b0;
            end
            if (w_accept) begin
                r_len   <= w_len_new;
                r_phase <= LW'(1);
                if (w_len_new > LW'(1)) begin
                    r_state <= S_STUFF;
                end
            end else if ((r_state == S_STUFF) && w_adv) begin
                if (r_phase == r_len - LW'(1)) begin
                    r_phase <= '0;
                    r_state <= S_WAIT;
                end else begin
                    r_phase <= r_phase + LW'(1);
                end
            end
        end
    end

    assign out_i     = r_out_i_p1;
    assign out_q     = r_out_q_p1;
    assign out_valid = r_vld_p1;

`ifdef UPSAMP_CAPTURE_EN
    upsamp_capture_buf #(
        .DATA_W (2 * OUT_W),
        .DEPTH  (CAP_DEPTH)
    ) u_cap (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cap_arm  (cap_arm),
        .i_wr_en    (r_vld_p1 && out_ready),
        .i_wr_data  ({r_out_i_p1, r_out_q_p1}),
        .o_cap_done (cap_done),
        .i_rd_addr  (cap_rd_addr),
        .o_rd_data  (cap_rd_data)
    );
`else
    logic w_unused_cap;
    assign w_unused_cap = ^{cap_arm, cap_rd_addr};
    assign cap_done     = 1'b0;
    assign cap_rd_data  = '0;
`endif

endmodule
